// File: rtl/varredura_display.sv
// varredura_display: multiplexed N-digit 7-segment scan driver with an all-off gap between digits,
// leading-zero blanking and a value snapshot taken once per frame when digit 0 comes up.
module varredura_display #(
  parameter int NUM_DIGITOS          = 4,
  parameter int TEMPO_APAGADO        = 4,
  parameter bit ANODO_ATIVO_BAIXO    = 1'b1,
  parameter bit SEGMENTO_ATIVO_BAIXO = 1'b1
) (
  input  logic                             clk_entrada,
  input  logic                             reset,
  input  logic                             clk_varredura,
  input  logic [4*NUM_DIGITOS-1:0]         valor,
  input  logic [NUM_DIGITOS-1:0]           pontos,
  input  logic                             supressao_zeros,
  input  logic                             habilita,
  output logic [NUM_DIGITOS-1:0]           anodos,
  output logic [6:0]                       segmentos,
  output logic                             ponto,
  output logic [$clog2(NUM_DIGITOS)-1:0]   digito_atual
);
  localparam int LI = $clog2(NUM_DIGITOS);
  localparam int LC = $clog2(TEMPO_APAGADO + 1);
  localparam logic [NUM_DIGITOS-1:0] ANODOS_OFF = {NUM_DIGITOS{ANODO_ATIVO_BAIXO}};
  localparam logic [6:0] SEG_OFF = {7{SEGMENTO_ATIVO_BAIXO}};
  typedef enum logic {APAGADO, EXIBINDO} estado_t;
  estado_t estado;
  logic [LC-1:0] contador;
  logic [LI-1:0] indice, proximo;
  logic anterior, pulso, carrega, apagar, ponto_dec;
  logic [4*NUM_DIGITOS-1:0] sombra, fonte;
  logic [NUM_DIGITOS-1:0] pontos_sombra, pontos_fonte, selecao, anodos_dec;
  logic [3:0] nibble;
  logic [6:0] seg_ativo, seg_dec;

  function automatic logic [6:0] decodifica(input logic [3:0] n);
    case (n)
      4'h0: decodifica = 7'b0111111;
      4'h1: decodifica = 7'b0000110;
      4'h2: decodifica = 7'b1011011;
      4'h3: decodifica = 7'b1001111;
      4'h4: decodifica = 7'b1100110;
      4'h5: decodifica = 7'b1101101;
      4'h6: decodifica = 7'b1111101;
      4'h7: decodifica = 7'b0000111;
      4'h8: decodifica = 7'b1111111;
      4'h9: decodifica = 7'b1101111;
      4'ha: decodifica = 7'b1110111;
      4'hb: decodifica = 7'b1111100;
      4'hc: decodifica = 7'b0111001;
      4'hd: decodifica = 7'b1011110;
      4'he: decodifica = 7'b1111001;
      default: decodifica = 7'b1110001;
    endcase
  endfunction

  assign pulso = clk_varredura & ~anterior;
  assign digito_atual = indice;

  // digit 0 is decoded from the snapshot being captured on the very same edge
  always_comb begin
    carrega = estado == APAGADO && contador == LC'(1) && indice == '0;
    fonte = carrega ? valor : sombra;
    pontos_fonte = carrega ? pontos : pontos_sombra;
    nibble = fonte[4*indice +: 4];
    apagar = supressao_zeros && indice != '0 && (fonte >> (4*indice)) == '0;
    seg_ativo = apagar ? 7'b0 : decodifica(nibble);
    seg_dec = SEGMENTO_ATIVO_BAIXO ? ~seg_ativo : seg_ativo;
    ponto_dec = pontos_fonte[indice] ^ SEGMENTO_ATIVO_BAIXO;
    selecao = NUM_DIGITOS'(1) << indice;
    anodos_dec = !habilita ? ANODOS_OFF : ANODO_ATIVO_BAIXO ? ~selecao : selecao;
    proximo = indice == LI'(NUM_DIGITOS - 1) ? '0 : indice + 1'b1;
  end

  always_ff @(posedge clk_entrada or posedge reset) begin
    if (reset) begin
      estado        <= APAGADO;
      contador      <= LC'(TEMPO_APAGADO);
      indice        <= '0;
      anterior      <= 1'b0;
      sombra        <= '0;
      pontos_sombra <= '0;
      anodos        <= ANODOS_OFF;
      segmentos     <= SEG_OFF;
      ponto         <= SEGMENTO_ATIVO_BAIXO;
    end else begin
      anterior <= clk_varredura;
      if (estado == APAGADO) begin
        anodos    <= ANODOS_OFF;
        segmentos <= SEG_OFF;
        ponto     <= SEGMENTO_ATIVO_BAIXO;
        if (contador == LC'(1)) begin
          estado    <= EXIBINDO;
          anodos    <= anodos_dec;
          segmentos <= seg_dec;
          ponto     <= ponto_dec;
          if (carrega) begin
            sombra        <= valor;
            pontos_sombra <= pontos;
          end
        end else begin
          contador <= contador - 1'b1;
        end
      end else if (pulso) begin
        estado    <= APAGADO;
        contador  <= LC'(TEMPO_APAGADO);
        indice    <= proximo;
        anodos    <= ANODOS_OFF;
        segmentos <= SEG_OFF;
        ponto     <= SEGMENTO_ATIVO_BAIXO;
      end else begin
        anodos    <= anodos_dec;
        segmentos <= seg_dec;
        ponto     <= ponto_dec;
      end
    end
  end
endmodule
